mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer that shares one single-port, fixed-latency memory between the instruction-fetch requester and the MEM-stage data requester of the MIPS processor. It grants one transaction at a time with round-robin priority on conflict, issues a one-cycle memory strobe, waits the configured latency, returns read data and pulses a per-requester acknowledge. The pipeline uses `busy` and the two acks to stall IF and MEM while their access is outstanding.

## Interface
- `ADDR_WIDTH`, 32, width of the address to memory (byte address, passed through untranslated)
- `DATA_WIDTH`, 32, width of the read and write data
- `MEM_LATENCY`, 2, cycles from the `mem_en` cycle to the cycle `mem_rdata` is valid; legal range 1..15
- `clk`  in  1  system clock, all state on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request, level; held until `if_ack`
- `if_addr`  in  ADDR_WIDTH  fetch address
- `if_rdata`  out  DATA_WIDTH  fetch read data, valid while `if_ack`=1, then held
- `if_ack`  out  1  one-cycle fetch-complete pulse
- `d_req`  in  1  data request, level; held until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_WIDTH  data address
- `d_wdata`  in  DATA_WIDTH  write data
- `d_rdata`  out  DATA_WIDTH  data read data, valid while `d_ack`=1, then held
- `d_ack`  out  1  one-cycle data-complete pulse
- `mem_en`  out  1  memory strobe, high exactly one cycle per transaction
- `mem_we`  out  1  memory write enable, high only together with `mem_en`
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_rdata`  in  DATA_WIDTH  memory read data
- `busy`  out  1  high whenever the state is not IDLE
- `owner`  out  1  0 = fetch, 1 = data; the current or most recent grantee

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE: samples the requests.
  - Only one request high: that requester is granted.
  - Both high: the requester not served last is granted.
  - No request: stay in IDLE.
  - On grant: latch the address, `we` and `wdata` (`we`=0 for fetch) into the `mem_*` outputs, set `owner`, update `last_served`, then go to ISSUE.
- ISSUE: `mem_en`=1 and `mem_we`=latched `we`, for one cycle. Load the counter with MEM_LATENCY-1, then go to WAIT.
- WAIT: lasts exactly MEM_LATENCY cycles, decrementing the counter. In the cycle the counter is 0:
  - For a read, capture `mem_rdata` into the owner's rdata register.
  - For a write, no rdata register changes.
  - Then go to DONE.
- DONE: the owner's ack = 1 for one cycle, then go to IDLE unconditionally. Requests are ignored in ISSUE, WAIT and DONE.
- Requester rule: a requester updates its req on the edge that ends its ack cycle. If req is still high in the following IDLE cycle, that is a new transaction.
- Request fields are sampled only at grant. Changes after grant have no effect.
- A req dropped before ack does not abort the transaction. It completes and the ack still pulses.
- `mem_addr` and `mem_wdata` hold their values until the next grant. `if_rdata` and `d_rdata` hold their values until their next read capture.
- Reset values:
  - State = IDLE.
  - All outputs = 0, including `owner`.
  - `last_served` = fetch, so data wins the first conflict.
  - Counter = 0.
- Reset mid-transaction: the transaction is aborted and no ack is issued. A write already strobed is not undone.

## Timing
- A request seen in IDLE at cycle t produces:
  - ISSUE (`mem_en`) at t+1.
  - WAIT at t+2..t+1+MEM_LATENCY, with `mem_rdata` sampled at t+1+MEM_LATENCY.
  - Ack at t+2+MEM_LATENCY.
- Request-to-ack latency is MEM_LATENCY+2 cycles. The next grant is no earlier than t+3+MEM_LATENCY.
- Back-to-back throughput: one transaction every MEM_LATENCY+3 cycles.
- Under continuous dual requests, grants alternate strictly. Neither requester waits more than one transaction.
- Counter width: 4 bits.

## Test plan
- Single fetch read, MEM_LATENCY=2: `if_req` at cycle 0 with `if_addr`=0x00400008, memory returns 0x2008000A in cycle 3. Required: `mem_en`=1 only in cycle 1, `if_ack`=1 in cycle 4 with `if_rdata`=0x2008000A, `d_ack` stays 0.
- Data write: `d_req`=1, `d_we`=1, `d_addr`=0x10010004, `d_wdata`=0xDEADBEEF. Required: `mem_en` and `mem_we` high together for one cycle with those address and data values, `d_ack` 4 cycles after the request, `d_rdata` unchanged.
- Conflict immediately after reset: both requests rise in the same cycle and stay high. Required grant order is data, fetch, data, fetch, with `owner` toggling and acks 5 cycles apart.
- Request-field change after grant: change `if_addr` from 0x0040000C to 0x00400010 while in WAIT. Required: `mem_addr` stays 0x0040000C until the next grant.
- Reset in WAIT: assert `reset` for one cycle during WAIT of a data read. Required: no `d_ack`, all outputs 0 the next cycle, state IDLE, and the next conflict is granted to data.
- MEM_LATENCY=1 and MEM_LATENCY=15: single reads produce acks at request+3 and request+17 cycles, with correct data captured.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between the fetch and data requesters.
// One transaction at a time, round-robin on conflict, registered strobe/ack outputs.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  owner
);

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic                  last_served_reg, last_served_next;
    logic                  owner_reg, owner_next;
    logic                  we_reg, we_next;
    logic                  mem_en_reg, mem_en_next;
    logic                  mem_we_reg, mem_we_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
    logic                  busy_reg, busy_next;
    logic [1:0]            ack_next;
    logic [1:0]            capture;
    logic                  grant_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= 4'd0;
            last_served_reg <= 1'b0;
            owner_reg       <= 1'b0;
            we_reg          <= 1'b0;
            mem_en_reg      <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            last_served_reg <= last_served_next;
            owner_reg       <= owner_next;
            we_reg          <= we_next;
            mem_en_reg      <= mem_en_next;
            mem_we_reg      <= mem_we_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            busy_reg        <= busy_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        last_served_next = last_served_reg;
        owner_next       = owner_reg;
        we_next          = we_reg;
        mem_en_next      = 1'b0;
        mem_we_next      = 1'b0;
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
        ack_next         = 2'b00;
        capture          = 2'b00;
        // Data wins when it is the only requester, or on conflict when fetch was served last.
        grant_data       = d_req && (!if_req || !last_served_reg);

        case (state_reg)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_next       = grant_data;
                    last_served_next = grant_data;
                    we_next          = grant_data && d_we;
                    mem_en_next      = 1'b1;
                    mem_we_next      = grant_data && d_we;
                    if (grant_data) begin
                        mem_addr_next  = d_addr;
                        mem_wdata_next = d_wdata;
                    end else begin
                        mem_addr_next  = if_addr;
                    end
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = CNT_LOAD;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    capture[owner_reg]  = !we_reg;
                    ack_next[owner_reg] = 1'b1;
                    state_next          = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // Per-requester read-data and acknowledge registers; index 0 = fetch, 1 = data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_WIDTH-1:0] rdata_reg;
            logic                  ack_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_reg <= '0;
                    ack_reg   <= 1'b0;
                end else begin
                    ack_reg <= ack_next[gi];
                    if (capture[gi]) begin
                        rdata_reg <= mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign if_rdata  = g_port[0].rdata_reg;
    assign if_ack    = g_port[0].ack_reg;
    assign d_rdata   = g_port[1].rdata_reg;
    assign d_ack     = g_port[1].ack_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = busy_reg;
    assign owner     = owner_reg;

endmodule
